// File: rtl/if_id_fifo.sv
// if_id_fifo: circular PC/instruction buffer between fetch and decode.
// Fetch pushes under if_valid_i/if_ready_o. Decode pops the oldest entry
// under id_valid_o/id_ready_i. A flush discards every buffered entry.
module if_id_fifo #(
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [31:0]                  if_pc_i,
  input  logic [31:0]                  if_inst_i,
  input  logic                         if_valid_i,
  output logic                         if_ready_o,
  output logic [31:0]                  id_pc_o,
  output logic [31:0]                  id_inst_o,
  output logic                         id_valid_o,
  input  logic                         id_ready_i,
  input  logic                         flush_i,
  output logic [$clog2(DEPTH+1)-1:0]   cnt_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [31:0]   r_pc_mem   [DEPTH];
  logic [31:0]   r_inst_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic w_ready;
  logic w_valid;
  logic w_push;
  logic w_pop;

  // Readiness and validity come from registered occupancy only, so a pop
  // in a full cycle cannot open room for a push in that same cycle.
  assign w_ready = (r_count != FULL_CNT);
  assign w_valid = (r_count != '0);
  assign w_push  = if_valid_i & w_ready & ~flush_i;
  assign w_pop   = w_valid & id_ready_i & ~flush_i;

  // Pointer and occupancy update; flush clears everything and wins over push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage: written only on an accepted push, no reset needed.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]   <= if_pc_i;
      r_inst_mem[r_wr_ptr] <= if_inst_i;
    end
  end

  // Head entry presented to decode; a NOP with PC 0 when nothing is buffered.
  always_comb begin
    id_pc_o   = '0;
    id_inst_o = NOP_INST;
    if (w_valid) begin
      id_pc_o   = r_pc_mem[r_rd_ptr];
      id_inst_o = r_inst_mem[r_rd_ptr];
    end
  end

  assign if_ready_o = w_ready;
  assign id_valid_o = w_valid;
  assign cnt_o      = r_count;

endmodule

// File: doc/if_id_fifo.md
Name: if_id_fifo

Overview:
- Decoupling buffer between the fetch stage and decode.
- Captures each fetched PC and its instruction word into a small circular FIFO, then presents the oldest entry to decode under a valid/ready handshake.
- Backpressure toward fetch is via if_ready_o; fetch holds its PC while it is low.
- Discards all wrong-path entries when a control transfer (decode jump or fnb jump) is taken.

Parameters:
- DEPTH, 2, number of entries; power of two, >= 2.
- NOP_INST, 32'h00000013, instruction word driven to decode when no entry is valid.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous active-high reset.
- if_pc_i  input  32  PC of the word being fetched this cycle.
- if_inst_i  input  32  instruction from ROM for if_pc_i, valid the same cycle.
- if_valid_i  input  1  fetch presents a valid PC/instruction pair.
- if_ready_o  output  1  buffer can accept a push this cycle.
- id_pc_o  output  32  PC of the head entry.
- id_inst_o  output  32  instruction of the head entry.
- id_valid_o  output  1  head entry is valid.
- id_ready_i  input  1  decode consumes the head entry this cycle.
- flush_i  input  1  control transfer taken (id_jump_en | fnb_jump); discard everything.
- cnt_o  output  $clog2(DEPTH+1)  number of valid entries.

Behaviour:
- Reset (async on rst=1, held until release):
  - wr_ptr = 0, rd_ptr = 0, count = 0; storage contents don't-care.
  - Outputs: if_ready_o=1, id_valid_o=0, id_inst_o=NOP_INST, id_pc_o=0, cnt_o=0.
- Handshakes:
  - push = if_valid_i & if_ready_o & ~flush_i.
  - pop = id_valid_o & id_ready_i & ~flush_i.
- Readiness and validity:
  - if_ready_o = (count != DEPTH). It depends only on registered state; there is no same-cycle pass-through of a pop.
  - id_valid_o = (count != 0).
- Output selection:
  - id_pc_o / id_inst_o read combinationally from storage[rd_ptr] when id_valid_o=1.
  - Otherwise they are 0 / NOP_INST.
- Latency: an entry pushed in cycle N is visible on the id_* outputs in cycle N+1 at the earliest. There is no combinational path from if_* to id_*.
- Pointers: log2(DEPTH) bits, wrap naturally from DEPTH-1 to 0.
  - push writes storage[wr_ptr] and increments wr_ptr.
  - pop increments rd_ptr.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged, pointers both advance.
  - neither: unchanged.
- Full (count == DEPTH):
  - if_ready_o=0; an offered fetch is not accepted and fetch must hold it.
  - A pop in the full cycle does not enable a push in that same cycle.
- Empty (count == 0): id_valid_o=0, so id_ready_i is ignored and no underflow is possible.
- Flush (highest priority after reset):
  - Next edge: wr_ptr = rd_ptr = 0, count = 0.
  - The same-cycle push is dropped (wrong-path fetch).
  - The same-cycle pop is not counted; the head entry is discarded along with the rest.
  - Combinational outputs in the flush cycle still reflect pre-flush state.
- Back-to-back flushes: the buffer simply stays empty.
- Reset mid-operation: state returns to reset values immediately, independent of clk; all entries are lost.
- Storage has no reset requirement and no enable other than push.
- Arithmetic: count is $clog2(DEPTH+1) bits and never exceeds DEPTH.

Test Plan:
1. Release reset with id_ready_i=1 and if_valid_i=1, pushing pc 0x0,0x4,0x8.
   -> id_valid_o rises 1 cycle after the first push; id_pc_o shows 0x0,0x4,0x8 on consecutive cycles; cnt_o stays 1.
2. DEPTH=2, id_ready_i=0, push 0x10,0x14,0x18.
   -> cnt_o=2 and if_ready_o=0 after two edges; 0x18 is not accepted.
   -> Raise id_ready_i: pops 0x10 then 0x14, then 0x18 is accepted and popped, in order.
3. Full buffer with id_ready_i=1 and if_valid_i=1 in the same cycle.
   -> Pop occurs, push is refused; cnt_o goes 2->1 and if_ready_o returns to 1 next cycle.
4. Two entries buffered; assert flush_i with if_valid_i=1 (pc 0x20) and id_ready_i=1.
   -> Next cycle cnt_o=0, id_valid_o=0, id_inst_o=0x00000013.
   -> Then push pc 0x100: it appears as the head with rd_ptr=0.
5. Run more than 2*DEPTH push/pop pairs with mixed stalls.
   -> Pointer wrap is correct; the output PC sequence matches the input sequence exactly, with no duplicates and no drops.
6. Assert rst asynchronously between clock edges while cnt_o=2.
   -> cnt_o=0, id_valid_o=0, if_ready_o=1 without waiting for a clock edge.
   -> After release, the first push appears normally.
